// File: rtl/shader_pkg.sv
// rtl/shader_pkg.sv - shared types and defaults for the warp scheduler
package shader_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READY    = 2'd1,
        WAIT_ALU = 2'd2,
        WAIT_MEM = 2'd3
    } warp_state_e;

    localparam int NUM_WARPS_DEF   = 16;
    localparam int ALU_LATENCY_DEF = 3;

endpackage

// File: rtl/warp_scheduler_rr_arbiter.sv
// rtl/warp_scheduler_rr_arbiter.sv - combinational N-way round-robin priority select
// Ports:
//   req         in  N  request vector
//   ptr         in  W  index with highest priority this cycle
//   grant_valid out 1  at least one request present
//   grant_idx   out W  first requester at or after ptr, wrapping
module rr_arbiter #(
    parameter int  N = 16,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx
);

    logic [W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester is the
    // last one written; N is a power of two so the W-bit add wraps for free.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = ptr + W'(i);
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/warp_scheduler.sv
// rtl/warp_scheduler.sv - per-warp state tracking and round-robin issue selection
// Optional build macro: WARP_SCHED_PERF_EN adds issue_count / stall_cycles.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   launch_valid/launch_id/ready     warp slot activation (ready = slot IDLE)
//   issue_valid/issue_warp/ready     offered warp, fire = valid & ready
//   issue_mem, issue_last            qualifiers of the fired instruction
//   mem_done_valid/mem_done_id       memory completion wakes a WAIT_MEM warp
//   busy, active_warps               any / count of non-IDLE warps
//   issue_count, stall_cycles        (perf build only) fire and stall counters
//   proto_err                        sticky protocol-error flag
module warp_scheduler
    import shader_pkg::*;
#(
    parameter int  NUM_WARPS   = NUM_WARPS_DEF,
    parameter int  ALU_LATENCY = ALU_LATENCY_DEF,
    localparam int WARP_ID_W   = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 launch_valid,
    input  logic [WARP_ID_W-1:0] launch_id,
    output logic                 launch_ready,
    output logic                 issue_valid,
    output logic [WARP_ID_W-1:0] issue_warp,
    input  logic                 issue_ready,
    input  logic                 issue_mem,
    input  logic                 issue_last,
    input  logic                 mem_done_valid,
    input  logic [WARP_ID_W-1:0] mem_done_id,
    output logic                 busy,
    output logic [WARP_ID_W:0]   active_warps,
`ifdef WARP_SCHED_PERF_EN
    output logic [31:0]          issue_count,
    output logic [31:0]          stall_cycles,
`else
`endif
    output logic                 proto_err
);

    localparam logic [3:0]         CNT_RELOAD = 4'(ALU_LATENCY - 1);
    localparam logic [WARP_ID_W:0] ONE_CNT    = (WARP_ID_W+1)'(1);

    warp_state_e            state_q [NUM_WARPS];
    warp_state_e            state_d [NUM_WARPS];
    logic [3:0]             cnt_q   [NUM_WARPS];
    logic [3:0]             cnt_d   [NUM_WARPS];
    logic [NUM_WARPS-1:0]   ready_vec;
    logic [WARP_ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic                   issue_valid_q, issue_valid_d;
    logic [WARP_ID_W-1:0]   issue_warp_q, issue_warp_d;
    logic [WARP_ID_W:0]     active_q, active_d;
    logic                   busy_q;
    logic                   proto_err_q, proto_err_d;
    logic                   grant_valid;
    logic [WARP_ID_W-1:0]   grant_idx;
    logic                   fire;

    assign launch_ready = (state_q[launch_id] == IDLE);
    assign fire         = issue_valid_q & issue_ready;

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            ready_vec[w] = (state_q[w] == READY);
        end
    end

    rr_arbiter #(.N(NUM_WARPS)) u_arb (
        .req         (ready_vec),
        .ptr         (rr_ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        proto_err_d = proto_err_q;
        // A mem_done racing its own fire also lands here: the warp is still READY.
        if (launch_valid && !launch_ready) proto_err_d = 1'b1;
        if (mem_done_valid && state_q[mem_done_id] != WAIT_MEM) proto_err_d = 1'b1;

        active_d = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            state_d[w] = state_q[w];
            cnt_d[w]   = cnt_q[w];
            case (state_q[w])
                IDLE: begin
                    if (launch_valid && launch_id == WARP_ID_W'(w)) state_d[w] = READY;
                end
                WAIT_ALU: begin
                    if (cnt_q[w] == 4'd0) state_d[w] = READY;
                    else                  cnt_d[w]   = cnt_q[w] - 4'd1;
                end
                WAIT_MEM: begin
                    if (mem_done_valid && mem_done_id == WARP_ID_W'(w)) state_d[w] = READY;
                end
                default: ;
            endcase
            // The fire update has the last word for the warp being issued.
            if (fire && issue_warp_q == WARP_ID_W'(w)) begin
                if (issue_last) begin
                    state_d[w] = IDLE;
                end else if (issue_mem) begin
                    state_d[w] = WAIT_MEM;
                end else begin
                    state_d[w] = WAIT_ALU;
                    cnt_d[w]   = CNT_RELOAD;
                end
            end
            if (state_d[w] != IDLE) active_d = active_d + ONE_CNT;
        end
    end

    // Once offered, the warp is locked until fire; the cycle after fire is
    // always a bubble so the arbiter sees the post-issue state vector.
    always_comb begin
        if (issue_valid_q) begin
            issue_valid_d = !fire;
            issue_warp_d  = issue_warp_q;
        end else begin
            issue_valid_d = grant_valid;
            issue_warp_d  = grant_valid ? grant_idx : issue_warp_q;
        end
        rr_ptr_d = fire ? issue_warp_q + WARP_ID_W'(1) : rr_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state_q[w] <= IDLE;
                cnt_q[w]   <= 4'd0;
            end
            rr_ptr_q      <= '0;
            issue_valid_q <= 1'b0;
            issue_warp_q  <= '0;
            active_q      <= '0;
            busy_q        <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state_q[w] <= state_d[w];
                cnt_q[w]   <= cnt_d[w];
            end
            rr_ptr_q      <= rr_ptr_d;
            issue_valid_q <= issue_valid_d;
            issue_warp_q  <= issue_warp_d;
            active_q      <= active_d;
            busy_q        <= (active_d != '0);
            proto_err_q   <= proto_err_d;
        end
    end

    assign issue_valid  = issue_valid_q;
    assign issue_warp   = issue_warp_q;
    assign active_warps = active_q;
    assign busy         = busy_q;
    assign proto_err    = proto_err_q;

`ifdef WARP_SCHED_PERF_EN
    logic [31:0] issue_count_q, stall_cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_count_q  <= '0;
            stall_cycles_q <= '0;
        end else begin
            if (fire)                    issue_count_q  <= issue_count_q + 32'd1;
            if (busy_q && !issue_valid_q) stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign issue_count  = issue_count_q;
    assign stall_cycles = stall_cycles_q;
`else
    // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_warp_scheduler.sv
// tb/tb_warp_scheduler.sv - scoreboard bench for warp_scheduler
module tb_warp_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       launch_valid = 1'b0;
    logic [3:0] launch_id = '0;
    logic       launch_ready;
    logic       issue_valid;
    logic [3:0] issue_warp;
    logic       issue_ready = 1'b0;
    logic       issue_mem = 1'b0;
    logic       issue_last = 1'b0;
    logic       mem_done_valid = 1'b0;
    logic [3:0] mem_done_id = '0;
    logic       busy;
    logic [4:0] active_warps;
    logic       proto_err;
`ifdef WARP_SCHED_PERF_EN
    logic [31:0] issue_count;
    logic [31:0] stall_cycles;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fires_m = 0;
    int stall_m = 0;
    int exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    warp_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .launch_valid   (launch_valid),
        .launch_id      (launch_id),
        .launch_ready   (launch_ready),
        .issue_valid    (issue_valid),
        .issue_warp     (issue_warp),
        .issue_ready    (issue_ready),
        .issue_mem      (issue_mem),
        .issue_last     (issue_last),
        .mem_done_valid (mem_done_valid),
        .mem_done_id    (mem_done_id),
        .busy           (busy),
        .active_warps   (active_warps),
`ifdef WARP_SCHED_PERF_EN
        .issue_count    (issue_count),
        .stall_cycles   (stall_cycles),
`endif
        .proto_err      (proto_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every fire pops the next expected warp from the scoreboard.
    always @(negedge clk) begin
        if (rst_n && issue_valid && issue_ready) begin
            fires_m++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_issue: got warp %0d expected none", issue_warp);
            end else begin
                chk("issue_order", 64'(issue_warp), 64'(exp_q.pop_front()));
            end
        end
        if (rst_n && busy && !issue_valid) stall_m++;
    end

    task automatic launch(input int id);
        launch_valid = 1'b1;
        launch_id    = 4'(id);
        @(posedge clk); #1;
        launch_valid = 1'b0;
    endtask

    task automatic issue(input int id, input bit mem, input bit last, output int fc);
        bit got = 1'b0;
        exp_q.push_back(id);
        issue_ready = 1'b1;
        issue_mem   = mem;
        issue_last  = last;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            if (issue_valid) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: got no offer expected warp %0d", id);
            void'(exp_q.pop_back());
        end
        @(posedge clk); #1;
        fc = cyc;
        issue_ready = 1'b0;
        issue_mem   = 1'b0;
        issue_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc, f0a, f0b, seen, lat;

        #12;
        chk("rst_issue_valid", 64'(issue_valid), 0);
        chk("rst_issue_warp", 64'(issue_warp), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_active", 64'(active_warps), 0);
        chk("rst_proto_err", 64'(proto_err), 0);
        chk("rst_launch_ready", 64'(launch_ready), 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 1: three warps round-robin with ALU latency spacing, then retire.
        launch(0); launch(1); launch(2);
        chk("t1_active", 64'(active_warps), 3);
        issue(0, 0, 0, f0a);
        issue(1, 0, 0, fc);
        issue(2, 0, 0, fc);
        issue(0, 0, 0, f0b);
        chk("t1_realu_gap_ok", 64'((f0b - f0a) >= 4), 1);
        issue(1, 0, 0, fc);
        issue(2, 0, 0, fc);
        issue(0, 0, 1, fc);
        issue(1, 0, 1, fc);
        issue(2, 0, 1, fc);
        chk("t1_busy_end", 64'(busy), 0);

        // Test 2: locked offer holds while another warp launches.
        launch(3); launch(5);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                launch_valid = 1'b1;
                launch_id    = 4'd4;
            end
            @(negedge clk);
            chk("t2_hold_valid", 64'(issue_valid), 1);
            chk("t2_hold_warp", 64'(issue_warp), 3);
            @(posedge clk); #1;
            launch_valid = 1'b0;
        end
        chk("t2_active", 64'(active_warps), 3);
        issue(3, 0, 0, fc);
        issue(4, 0, 0, fc);
        issue(5, 0, 0, fc);
        issue(3, 0, 1, fc);
        issue(4, 0, 1, fc);
        issue(5, 0, 1, fc);

        // Test 3: memory wait blocks the warp until its completion.
        launch(7);
        issue(7, 1, 0, fc);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (issue_valid) seen++;
        end
        chk("t3_no_offer_in_mem", 64'(seen), 0);
        @(posedge clk); #1;
        mem_done_valid = 1'b1;
        mem_done_id    = 4'd7;
        @(posedge clk); #1;
        mem_done_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (issue_valid && lat == 0) lat = i;
        end
        chk("t3_wake_latency", 64'(lat), 2);
        chk("t3_wake_warp", 64'(issue_warp), 7);
        chk("t3_proto_clean", 64'(proto_err), 0);
        @(posedge clk); #1;
        issue(7, 0, 1, fc);

        // Test 4: warp exit frees the slot and drops the count.
        launch(2); launch(6);
        chk("t4_active2", 64'(active_warps), 2);
        launch_id = 4'd2;
        #1 chk("t4_slot2_busy", 64'(launch_ready), 0);
        issue(2, 0, 1, fc);
        chk("t4_active1", 64'(active_warps), 1);
        launch_id = 4'd2;
        #1 chk("t4_slot2_free", 64'(launch_ready), 1);
        chk("t4_busy_mid", 64'(busy), 1);
        issue(6, 0, 1, fc);
        chk("t4_busy_end", 64'(busy), 0);
        chk("t4_active0", 64'(active_warps), 0);

        // Test 5a: completion for an idle warp is flagged and sticks.
        mem_done_valid = 1'b1;
        mem_done_id    = 4'd9;
        @(posedge clk); #1;
        mem_done_valid = 1'b0;
        chk("t5_memdone_err", 64'(proto_err), 1);
        chk("t5_memdone_active", 64'(active_warps), 0);
        repeat (3) @(posedge clk);
        #1 chk("t5_sticky", 64'(proto_err), 1);

        // Test 6: reset with warps in WAIT_ALU and WAIT_MEM.
        launch(0); launch(1); launch(2); launch(3);
        issue(0, 1, 0, fc);
        issue(1, 1, 0, fc);
        issue(2, 0, 0, fc);
        issue(3, 0, 0, fc);
        chk("t6_active4", 64'(active_warps), 4);
`ifdef WARP_SCHED_PERF_EN
        chk("t6_issue_count", 64'(issue_count), 64'(fires_m));
        chk("t6_stall_cycles", 64'(stall_cycles), 64'(stall_m));
`else
`endif
        launch_id = 4'd3;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_issue_valid", 64'(issue_valid), 0);
        chk("t6_rst_issue_warp", 64'(issue_warp), 0);
        chk("t6_rst_busy", 64'(busy), 0);
        chk("t6_rst_active", 64'(active_warps), 0);
        chk("t6_rst_proto_err", 64'(proto_err), 0);
        chk("t6_rst_launch_ready", 64'(launch_ready), 1);
`ifdef WARP_SCHED_PERF_EN
        chk("t6_rst_issue_count", 64'(issue_count), 0);
        chk("t6_rst_stall_cycles", 64'(stall_cycles), 0);
`else
`endif
        fires_m = 0;
        stall_m = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 5b: launch to a READY slot is ignored and flagged.
        launch(5);
        chk("t5b_proto_before", 64'(proto_err), 0);
        launch(5);
        chk("t5b_launch_err", 64'(proto_err), 1);
        chk("t5b_active", 64'(active_warps), 1);
        issue(5, 0, 1, fc);
        chk("t5b_busy_end", 64'(busy), 0);
        chk("t5b_sticky", 64'(proto_err), 1);
        chk("scoreboard_drained", 64'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/warp_scheduler.md
Name: warp_scheduler

Overview:
- Sequences the shader core's SIMD ALU array across up to NUM_WARPS resident warps.
- Tracks per-warp state (idle, ready, ALU-latency wait, memory wait) and selects one ready warp per cycle round-robin.
- Presents the selected warp to the instruction-issue stage over a valid/ready handshake.
- Sits between the warp launch interface and the decode/issue logic that feeds the ALUs.

Parameters:
- NUM_WARPS, 16, number of warp slots; power of two, 2..64.
- ALU_LATENCY, 3, cycles from issue until the warp may issue again; 1..15.
- WARP_ID_W, $clog2(NUM_WARPS), warp index width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- launch_valid  in  1  request to activate a warp slot.
- launch_id  in  WARP_ID_W  slot to activate.
- launch_ready  out  1  high when slot launch_id is IDLE.
- issue_valid  out  1  a warp is offered for issue.
- issue_warp  out  WARP_ID_W  offered warp.
- issue_ready  in  1  issue stage accepts; fire = issue_valid & issue_ready.
- issue_mem  in  1  issued instruction is a memory op; sampled on fire.
- issue_last  in  1  issued instruction ends the warp; sampled on fire.
- mem_done_valid  in  1  memory completion.
- mem_done_id  in  WARP_ID_W  warp whose memory op completed.
- busy  out  1  any warp not IDLE.
- active_warps  out  WARP_ID_W+1  count of non-IDLE warps.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Per-warp states: IDLE, READY, WAIT_ALU, WAIT_MEM. Each WAIT_ALU warp has a 4-bit countdown.
- Reset: all warps IDLE, counters 0, rr pointer 0, issue_valid=0, issue_warp=0, busy=0, active_warps=0, proto_err=0.
- Launch:
  - IDLE->READY when launch_valid & launch_ready; registered, so eligible the next cycle.
  - launch_ready is combinational: state[launch_id]==IDLE.
  - launch_valid to a non-IDLE slot: ignored, proto_err set.
- Selection:
  - When not locked, pick the first READY warp searching from rr_ptr upward with wrap-around.
  - issue_valid/issue_warp are registered (one cycle after the warp becomes READY).
  - Lock: once issue_valid=1, issue_warp holds until fire, even if other warps become ready.
- On fire for warp w:
  - rr_ptr <= w+1 (mod NUM_WARPS).
  - If issue_last: w->IDLE (issue_mem ignored).
  - Else if issue_mem: w->WAIT_MEM.
  - Else: w->WAIT_ALU, counter<=ALU_LATENCY-1.
  - issue_valid drops for at least one cycle after fire (re-selection cycle).
- WAIT_ALU: counter decrements each cycle; at counter==0 the warp goes READY the next cycle. Net effect: a warp issued at cycle t is offered again no earlier than t+ALU_LATENCY+1.
- WAIT_MEM: goes READY on mem_done_valid with mem_done_id==w. mem_done for a warp not in WAIT_MEM is ignored and sets proto_err.
- Simultaneous events:
  - A launch targeting the warp currently firing cannot occur (slot is not IDLE), so it follows the rule above.
  - A mem_done arriving in the same cycle as its own issue fire is a protocol error; the fire update wins.
- busy and active_warps are registered from the next-state vector, so they update in the same cycle as the state change.
- Reset mid-operation returns everything to reset values immediately; in-flight work is discarded.

Optional Feature:
- Macro: WARP_SCHED_PERF_EN.
- Defined: adds out ports issue_count[31:0] (increments per fire) and stall_cycles[31:0] (increments each cycle busy & !issue_valid). Both reset to 0 and wrap at 2^32.
- Undefined: ports are absent and no counter logic is generated.

Decomposition:
- shader_pkg:
  - warp_state_e enum (IDLE=2'd0, READY=2'd1, WAIT_ALU=2'd2, WAIT_MEM=2'd3).
  - Default constants NUM_WARPS_DEF=16, ALU_LATENCY_DEF=3.
- Sub-module rr_arbiter:
  - Parameterised N-way round-robin priority select.
  - Inputs: req vector, ptr. Outputs: grant_valid, grant_idx.
  - Combinational; the lock register stays in warp_scheduler.

Test Plan:
1. Launch warps 0,1,2 in consecutive cycles, issue_ready=1, non-mem ops -> issue order 0,1,2,0,... and warp 0 reissued no earlier than 4 cycles after its first fire.
2. Warps 3 and 5 READY, issue_ready=0 for 5 cycles while warp 4 launches -> issue_warp stays 3; after release the order is 3,4,5.
3. Warp 7 issues with issue_mem=1 -> never offered until mem_done_valid, mem_done_id=7, then offered 1-2 cycles later.
4. Warp 2 issues with issue_last=1 -> active_warps decrements by 1, launch_ready for id 2 returns high; final warp exit -> busy=0.
5. Launch to a READY slot, or mem_done for an IDLE warp -> state unchanged, proto_err=1 and stays high until reset.
6. Assert rst_n low with 4 warps mid-WAIT_ALU/WAIT_MEM -> all outputs reach reset values asynchronously; (PERF_EN) issue_count=0 and stall_cycles=0.
